// File: rtl/serial_addsub_digit_if.sv
// Bus bundle for the digit-serial adder/subtractor.
//
// Handshake: the master raises start for one or more cycles together with
// sub/a/b; the slave samples them on a rising edge only while busy is low,
// and ignores start (and any operand changes) while busy is high. done is a
// single-cycle pulse marking the cycle in which result/carry_out/overflow
// have just been updated; sum_digit is meaningful only while
// sum_digit_valid is high and holds its last value otherwise.
interface serial_addsub_digit_if #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic [DIGIT-1:0] sum_digit;
   logic             sum_digit_valid;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, carry_out, overflow, sum_digit, sum_digit_valid
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, carry_out, overflow, sum_digit, sum_digit_valid
   );
endinterface

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
// dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 DONE).
module serial_addsub_digit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_addsub_digit_if.slave bus,
   output logic [1:0]           dbg_state
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nxt;
   logic             c;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;
   logic [DIGIT-1:0] d;
   logic             c_nxt;
   logic             cmsb;
   logic             last;

   logic [WIDTH-1:0] result_r;
   logic             carry_out_r, overflow_r, done_r, valid_r;
   logic [DIGIT-1:0] sum_digit_r;

   // Digit adder on the low digit of the shift registers plus the running carry.
   assign dsum  = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
   assign d     = dsum[DIGIT-1:0];
   assign c_nxt = dsum[DIGIT];
   // Carry into the top bit of this digit; on the last digit that is the carry into the MSB.
   assign cmsb  = d[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
   assign last  = (cnt == CW'(N - 1));

   // The new digit enters the accumulator from the top, so after N digits it is aligned.
   generate
      if (DIGIT == WIDTH) begin : g_acc_full
         assign acc_nxt = d;
      end else begin : g_acc_shift
         assign acc_nxt = {d, acc[WIDTH-1:DIGIT]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_RUN;
         S_RUN:   if (last)      state_nxt = S_DONE;
         S_DONE:                 state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch operands on start, process one digit per RUN cycle, publish on the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr        <= '0;
         b_sr        <= '0;
         acc         <= '0;
         c           <= 1'b0;
         cnt         <= '0;
         result_r    <= '0;
         carry_out_r <= 1'b0;
         overflow_r  <= 1'b0;
         done_r      <= 1'b0;
         valid_r     <= 1'b0;
         sum_digit_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done_r  <= 1'b0;
               valid_r <= 1'b0;
               if (bus.start) begin
                  a_sr <= bus.a;
                  b_sr <= bus.sub ? ~bus.b : bus.b;
                  c    <= bus.sub;
                  cnt  <= '0;
                  acc  <= '0;
               end
            end
            S_RUN: begin
               a_sr        <= a_sr >> DIGIT;
               b_sr        <= b_sr >> DIGIT;
               c           <= c_nxt;
               acc         <= acc_nxt;
               sum_digit_r <= d;
               valid_r     <= 1'b1;
               cnt         <= cnt + CW'(1);
               if (last) begin
                  result_r    <= acc_nxt;
                  carry_out_r <= c_nxt;
                  overflow_r  <= cmsb ^ c_nxt;
                  done_r      <= 1'b1;
               end
            end
            S_DONE: begin
               done_r  <= 1'b0;
               valid_r <= 1'b0;
            end
            default: begin
               done_r  <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy            = (state != S_IDLE);
   assign bus.done            = done_r;
   assign bus.result          = result_r;
   assign bus.carry_out       = carry_out_r;
   assign bus.overflow        = overflow_r;
   assign bus.sum_digit       = sum_digit_r;
   assign bus.sum_digit_valid = valid_r;
   assign dbg_state           = state;
endmodule

// File: tb/tb_serial_addsub_digit.sv
// Bench for serial_addsub_digit: an 8-bit DIGIT=1 and an 8-bit DIGIT=4
// instance run the same operations side by side. Expected results come from
// plain integer arithmetic; monitors pop them when the DUTs present output.
module tb_serial_addsub_digit;
   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_addsub_digit_if #(.WIDTH(W), .DIGIT(1)) bus1 ();
   serial_addsub_digit_if #(.WIDTH(W), .DIGIT(4)) bus4 ();
   logic [1:0] dbg1, dbg4;

   serial_addsub_digit #(.WIDTH(W), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1)
   );
   serial_addsub_digit #(.WIDTH(W), .DIGIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(dbg4)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [W+1:0] exp_q1[$];   // {carry_out, overflow, result}
   logic [W+1:0] exp_q4[$];
   logic [0:0]   dig_q1[$];
   logic [3:0]   dig_q4[$];
   logic [W+1:0] hr1 = '0, hr4 = '0;   // last completed result (held value)
   logic [0:0]   hd1 = '0;
   logic [3:0]   hd4 = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer add with two's-complement subtract.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      int unsigned   full;
      logic [W-1:0]  bv;
      logic [W-1:0]  r;
      logic          ovf;
      bv   = s ? ~b : b;
      full = int'(a) + int'(bv) + int'(s);
      r    = full[W-1:0];
      ovf  = (a[W-1] == bv[W-1]) && (r[W-1] != a[W-1]);
      return {full[W], ovf, r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic st);
      bus1.a = a; bus1.b = b; bus1.sub = s; bus1.start = st;
      bus4.a = a; bus4.b = b; bus4.sub = s; bus4.start = st;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_d1"}, {bus1.busy, bus1.done, bus1.result, bus1.carry_out, bus1.overflow,
                         bus1.sum_digit, bus1.sum_digit_valid, dbg1}, 0);
      chk({tag, "_d4"}, {bus4.busy, bus4.done, bus4.result, bus4.carry_out, bus4.overflow,
                         bus4.sum_digit, bus4.sum_digit_valid, dbg4}, 0);
   endtask

   // mode 0: plain op; 1: extra start pulse mid-run; 2: reset pulse mid-run.
   // Called at a negedge with both DUTs idle; returns at a negedge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int mode);
      logic [W+1:0] e;
      int cyc, lat1, lat4, bz1, bz4;
      e = model(a, b, s);
      exp_q1.push_back(e);
      exp_q4.push_back(e);
      for (int i = 0; i < W; i++) dig_q1.push_back(e[i]);
      for (int i = 0; i < W / 4; i++) dig_q4.push_back(e[i*4 +: 4]);
      set_in(a, b, s, 1'b1);
      @(posedge clk);
      #1 bus1.start = 1'b0; bus4.start = 1'b0;
      cyc = 1; lat1 = -1; lat4 = -1; bz1 = 0; bz4 = 0;
      while (cyc <= 40) begin
         @(negedge clk);
         if (mode == 2 && cyc == 2) begin
            #2 rst_n = 1'b0;
            #1 check_idle("reset_abort");
            exp_q1.delete(); exp_q4.delete(); dig_q1.delete(); dig_q4.delete();
            hr1 = '0; hr4 = '0; hd1 = '0; hd4 = '0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (bus1.busy) bz1++;
         if (bus4.busy) bz4++;
         if (bus1.done) lat1 = cyc;
         if (bus4.done) lat4 = cyc;
         if (lat1 > 0 && lat4 > 0 && !bus1.busy && !bus4.busy) break;
         if (mode == 1 && cyc == 2) set_in(8'hFF, 8'($urandom), ~s, 1'b1);
         @(posedge clk);
         #1 bus1.start = 1'b0; bus4.start = 1'b0;
         cyc++;
      end
      chk("latency_d1", lat1, W + 1);
      chk("latency_d4", lat4, W / 4 + 1);
      chk("busy_cycles_d1", bz1, W + 1);
      chk("busy_cycles_d4", bz4, W / 4 + 1);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus1.sum_digit_valid) begin
            if (dig_q1.size() == 0) chk("d1_digit_unexpected", dig_q1.size(), 1);
            else begin
               hd1 = dig_q1.pop_front();
               chk("d1_digit", bus1.sum_digit, hd1);
            end
         end else chk("d1_digit_hold", bus1.sum_digit, hd1);
         if (bus1.done) begin
            chk("d1_done_with_valid", bus1.sum_digit_valid, 1);
            if (exp_q1.size() == 0) chk("d1_done_unexpected", exp_q1.size(), 1);
            else begin
               hr1 = exp_q1.pop_front();
               chk("d1_result", {bus1.carry_out, bus1.overflow, bus1.result}, hr1);
            end
         end else chk("d1_result_hold", {bus1.carry_out, bus1.overflow, bus1.result}, hr1);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus4.sum_digit_valid) begin
            if (dig_q4.size() == 0) chk("d4_digit_unexpected", dig_q4.size(), 1);
            else begin
               hd4 = dig_q4.pop_front();
               chk("d4_digit", bus4.sum_digit, hd4);
            end
         end else chk("d4_digit_hold", bus4.sum_digit, hd4);
         if (bus4.done) begin
            chk("d4_done_with_valid", bus4.sum_digit_valid, 1);
            if (exp_q4.size() == 0) chk("d4_done_unexpected", exp_q4.size(), 1);
            else begin
               hr4 = exp_q4.pop_front();
               chk("d4_result", {bus4.carry_out, bus4.overflow, bus4.result}, hr4);
            end
         end else chk("d4_result_hold", {bus4.carry_out, bus4.overflow, bus4.result}, hr4);
      end
   end

   // ---------------- main sequence and final report ----------------
   initial begin
      set_in('0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 check_idle("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h0B, 8'h0D, 1'b0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      run_op(8'h05, 8'h07, 1'b1, 0);
      run_op(8'h80, 8'h01, 1'b1, 0);
      run_op(8'h3C, 8'h4B, 1'b0, 0);
      run_op(8'h5A, 8'h21, 1'b0, 1);
      run_op(8'h11, 8'h22, 1'b1, 0);
      run_op(8'hC3, 8'h3C, 1'b1, 2);
      run_op(8'h01, 8'h01, 1'b0, 0);
      repeat (40) run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);

      repeat (3) @(negedge clk);
      chk("leftover_results_d1", exp_q1.size(), 0);
      chk("leftover_results_d4", exp_q4.size(), 0);
      chk("leftover_digits_d1", dig_q1.size(), 0);
      chk("leftover_digits_d4", dig_q4.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
